dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Memory-side responder for the CPU's MEM stage. It accepts one load or store request at a time over a valid/ready handshake and returns a response after a programmable access latency.
- The MEM stage stalls on !req_ready and !rsp_valid. This lets the pipeline model a slow data memory in place of the zero-wait array.
- Word-organised internal storage. Little-endian byte lanes. Supports byte, half and word accesses with sign or zero extension on loads.

Parameters:
- DEPTH, 1024, number of 32-bit words of storage (power of two, >=4).
- LATENCY, 2, cycles spent in BUSY before a response is presented (>=1).

Ports:
- clk  input  1  clock; all state changes on posedge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_wen  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts response.
- rsp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- rsp_err  output  1  request was misaligned, illegal-size or out of range.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: state = IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, latency counter = 0.
- Storage array is not cleared by reset.
- FSM states and transitions:
  - IDLE: req_ready = 1. On req_valid, latch addr/size/unsigned/wen/wdata, load counter = LATENCY-1, go to BUSY.
  - BUSY: req_ready = 0. Counter decrements each cycle. When counter == 0, perform the access, register rsp_rdata/rsp_err, go to RESP.
  - RESP: rsp_valid = 1, with rsp_rdata/rsp_err held stable. On rsp_ready, go to IDLE.
- Latency and throughput:
  - Accept edge to rsp_valid high is exactly LATENCY+1 cycles.
  - A new request is accepted no earlier than the cycle after rsp_valid && rsp_ready; no overlap of request and response.
  - rsp_valid is held indefinitely while rsp_ready = 0; no timeout.
- Request stability: request inputs are sampled only on the accept edge. Changes while BUSY or in RESP are ignored.
- Error conditions (evaluated on the latched request):
  - size 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - addr[31:2] >= DEPTH.
  - On error: no array write, rsp_err = 1, rsp_rdata = 0. Full latency still applies.
- Store:
  - Commits on the BUSY -> RESP edge, not at accept.
  - Byte enables derived from size and addr[1:0]; data replicated into the selected lane(s). Unselected bytes unchanged.
  - Response: rsp_rdata = 0, rsp_err = 0.
- Load:
  - Word read at addr[31:2]; lane selected by addr[1:0].
  - Extended by req_unsigned: byte from bit 7, half from bit 15. Word loads ignore req_unsigned.
- Reset mid-operation: returns to IDLE immediately.
  - A store in BUSY that has not committed is discarded.
  - A response pending in RESP is dropped.
  - Committed array contents are retained.
- req_valid asserted while not in IDLE: ignored; it is not queued.

Decomposition:
- define.vh additions:
  - MEM_SIZE_B = 2'b00, MEM_SIZE_H = 2'b01, MEM_SIZE_W = 2'b10.
  - FSM state encodings DMR_IDLE, DMR_BUSY, DMR_RESP.
- One combinational sub-module, dmem_lane_align:
  - Inputs: size, addr[1:0], wdata, read word, unsigned.
  - Outputs: byte enables[3:0], aligned write word, extended load data, misalign flag.
  - Reused later by the MEM stage and a future cache.

Test Plan:
- After reset, store word: wen = 1, size = W, addr = 0x10, wdata = 0xDEADBEEF. Then load word from 0x10 -> rsp_rdata = 0xDEADBEEF, rsp_err = 0; rsp_valid rises exactly LATENCY+1 cycles after each accept.
- Byte/half extension on word 0xDEADBEEF at 0x10:
  - Byte at 0x13, signed -> 0xFFFFFFDE; unsigned -> 0x000000DE.
  - Half at 0x12, signed -> 0xFFFFDEAD.
  - Store byte 0x55 at 0x11, then load word 0x10 -> 0xDEAD55EF.
- Misaligned and illegal requests:
  - Word load at 0x12 -> rsp_err = 1, rsp_rdata = 0.
  - Half store at 0x11 with wdata 0x1234 -> rsp_err = 1; following word load at 0x10 unchanged.
  - addr = DEPTH*4 -> rsp_err = 1.
- Backpressure: hold rsp_ready = 0 for 5 cycles after rsp_valid -> rsp_valid and rsp_rdata stable, req_ready = 0 throughout; accept only after the handshake.
- Reset mid-operation: issue store 0xCAFEF00D to 0x20 (prior content 0x0), assert reset during BUSY -> outputs return to reset values; subsequent load of 0x20 -> 0x00000000.
- Ignored requests: pulse req_valid with a different address while BUSY -> no second response; response data matches the first request only.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-size codes and FSM states.
package dmem_responder_pkg;

  localparam logic [1:0] MEM_SIZE_B = 2'b00;
  localparam logic [1:0] MEM_SIZE_H = 2'b01;
  localparam logic [1:0] MEM_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    DMR_IDLE = 2'd0,
    DMR_BUSY = 2'd1,
    DMR_RESP = 2'd2
  } dmr_state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian byte-lane steering for 32-bit word storage: store lane enables and
// replication, load lane selection with sign/zero extension, and alignment checking.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  input  logic        is_unsigned,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rdata,
  output logic        misalign
);

  logic [31:0] rsel;

  always_comb begin
    byte_en  = '0;
    wword    = '0;
    rdata    = '0;
    rsel     = '0;
    misalign = 1'b0;
    case (size)
      MEM_SIZE_B: begin
        byte_en = 4'b0001 << addr_lo;
        wword   = {4{wdata[7:0]}};
        rsel    = rword >> {addr_lo, 3'b000};
        rdata   = {{24{~is_unsigned & rsel[7]}}, rsel[7:0]};
      end
      MEM_SIZE_H: begin
        misalign = addr_lo[0];
        byte_en  = 4'b0011 << addr_lo;
        wword    = {2{wdata[15:0]}};
        rsel     = rword >> {addr_lo[1], 4'b0000};
        rdata    = {{16{~is_unsigned & rsel[15]}}, rsel[15:0]};
      end
      MEM_SIZE_W: begin
        misalign = (addr_lo != 2'b00);
        byte_en  = 4'b1111;
        wword    = wdata;
        rdata    = rword;
      end
      // Size 11 is reported through the same flag as misalignment.
      default: misalign = 1'b1;
    endcase
    if (misalign) byte_en = '0;
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable access latency,
// valid/ready request and response channels, and byte/half/word access.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  dmr_state_t  state;
  logic [CW-1:0] cnt;

  logic        wen_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [31:0]   wword;
  logic [31:0]   ldata;
  logic [3:0]    byte_en;
  logic          misalign;
  logic          oor;
  logic          err;
  logic          accept;
  logic          access;
  logic          commit;

  assign idx    = addr_q[AW+1:2];
  assign rword  = mem[idx];
  assign oor    = ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  assign err    = oor | misalign;
  assign accept = (state == DMR_IDLE) && req_valid;
  assign access = (state == DMR_BUSY) && (cnt == '0);
  assign commit = access && wen_q && !err;

  dmem_lane_align u_align (
    .size        (size_q),
    .addr_lo     (addr_q[1:0]),
    .wdata       (wdata_q),
    .rword       (rword),
    .is_unsigned (uns_q),
    .byte_en     (byte_en),
    .wword       (wword),
    .rdata       (ldata),
    .misalign    (misalign)
  );

  // Request capture: only the accept edge samples the request bus.
  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= req_wen;
      uns_q   <= req_unsigned;
      size_q  <= req_size;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset.
  always_ff @(posedge clk) begin
    if (commit) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= DMR_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        DMR_IDLE: begin
          if (req_valid) begin
            state     <= DMR_BUSY;
            cnt       <= CNT_LOAD;
            req_ready <= 1'b0;
          end
        end
        DMR_BUSY: begin
          if (cnt == '0) begin
            rsp_rdata <= (err || wen_q) ? 32'h0 : ldata;
            rsp_err   <= err;
            rsp_valid <= 1'b1;
            state     <= DMR_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DMR_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state     <= DMR_IDLE;
          end
        end
        default: begin
          state     <= DMR_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios followed by randomized
// traffic compared against a byte-addressed reference memory.
module tb_dmem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_wen = 1'b0;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  ref_mem [DEPTH*4];
  logic [31:0] got_rdata;
  logic        got_err;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_wen      (req_wen),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: byte-addressed memory, size in bytes = 1 << size.
  task automatic ref_access(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                            input logic uns, input logic [31:0] wdata,
                            output logic [31:0] rd, output logic er);
    int n;
    logic [31:0] v;
    er = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
         (size == 2'd2 && addr[1:0] != 2'd0) || ({2'b00, addr[31:2]} >= 32'(DEPTH));
    rd = '0;
    if (!er) begin
      n = 1 << size;
      if (wen) begin
        for (int i = 0; i < n; i++) ref_mem[int'(addr) + i] = wdata[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (!uns && size == 2'd0 && v[7])  v[31:8]  = '1;
        if (!uns && size == 2'd1 && v[15]) v[31:16] = '1;
        rd = v;
      end
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                       input logic uns, input logic [31:0] wdata);
    req_wen = wen; req_addr = addr; req_size = size; req_unsigned = uns; req_wdata = wdata;
    req_valid = 1'b1;
    chk("accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    // Request bus is only sampled at accept; scramble it afterwards.
    req_wen = 1'($urandom); req_addr = $urandom; req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_wdata = $urandom;
  endtask

  // Returns the number of clock edges after the accept edge until rsp_valid is seen.
  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      chk("busy_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic finish_rsp(input int delay);
    repeat (delay) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid), 32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("req_ready_back", 32'(req_ready), 32'd1);
  endtask

  // rsp_valid is expected LATENCY edges after the accept edge, i.e. LATENCY+1
  // cycles counting the cycle in which the request was accepted.
  task automatic xact(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                      input logic uns, input logic [31:0] wdata, input int delay,
                      input string tag);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;
    ref_access(wen, addr, size, uns, wdata, exp_rd, exp_err);
    issue(wen, addr, size, uns, wdata);
    wait_rsp(lat);
    chk({tag, "_lat"}, 32'(lat), 32'(LATENCY));
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    chk({tag, "_rdata"}, got_rdata, exp_rd);
    chk({tag, "_err"}, 32'(got_err), 32'(exp_err));
    finish_rsp(delay);
  endtask

  initial begin
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // Basic store/load and extension
    xact(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF, 0, "st_w");
    xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "ld_w");
    chk("tp_ld_w", got_rdata, 32'hDEADBEEF);
    xact(1'b0, 32'h13, 2'd0, 1'b0, 32'h0, 0, "ld_bs");
    chk("tp_ld_bs", got_rdata, 32'hFFFFFFDE);
    xact(1'b0, 32'h13, 2'd0, 1'b1, 32'h0, 0, "ld_bu");
    chk("tp_ld_bu", got_rdata, 32'h000000DE);
    xact(1'b0, 32'h12, 2'd1, 1'b0, 32'h0, 0, "ld_hs");
    chk("tp_ld_hs", got_rdata, 32'hFFFFDEAD);
    xact(1'b1, 32'h11, 2'd0, 1'b0, 32'h55, 0, "st_b");
    xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "ld_w2");
    chk("tp_ld_w2", got_rdata, 32'hDEAD55EF);

    // Errors
    xact(1'b0, 32'h12, 2'd2, 1'b0, 32'h0, 0, "mis_w");
    chk("tp_mis_w_err", 32'(got_err), 32'd1);
    xact(1'b1, 32'h11, 2'd1, 1'b0, 32'h1234, 0, "mis_h");
    chk("tp_mis_h_err", 32'(got_err), 32'd1);
    xact(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, 0, "ld_w3");
    chk("tp_ld_w3", got_rdata, 32'hDEAD55EF);
    xact(1'b0, 32'(DEPTH*4), 2'd2, 1'b0, 32'h0, 0, "oor");
    chk("tp_oor_err", 32'(got_err), 32'd1);
    xact(1'b0, 32'h10, 2'd3, 1'b0, 32'h0, 0, "ill");
    chk("tp_ill_err", 32'(got_err), 32'd1);

    // Reset during BUSY discards an uncommitted store
    xact(1'b1, 32'h20, 2'd2, 1'b0, 32'h0, 0, "pre0");
    issue(1'b1, 32'h20, 2'd2, 1'b0, 32'hCAFEF00D);
    reset = 1'b0;
    #1;
    chk("mid_rst_req_ready", 32'(req_ready), 32'd1);
    chk("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_rsp_err", 32'(rsp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, "ld_after_rst");
    chk("tp_ld_after_rst", got_rdata, 32'h0);

    // Backpressure: response held, a store attempted meanwhile is not accepted
    ref_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, exp_rd, exp_err);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    wait_rsp(lat);
    chk("bp_lat", 32'(lat), 32'(LATENCY));
    req_valid = 1'b1; req_wen = 1'b1; req_addr = 32'h20; req_size = 2'd2;
    req_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, 32'hDEAD55EF);
      chk("bp_req_ready", 32'(req_ready), 32'd0);
    end
    req_valid = 1'b0;
    finish_rsp(0);
    xact(1'b0, 32'h20, 2'd2, 1'b0, 32'h0, 0, "bp_noacc");
    chk("tp_bp_noacc", got_rdata, 32'h0);

    // Request pulsed while BUSY is neither served nor queued
    ref_access(1'b0, 32'h10, 2'd2, 1'b0, 32'h0, exp_rd, exp_err);
    issue(1'b0, 32'h10, 2'd2, 1'b0, 32'h0);
    req_valid = 1'b1; req_wen = 1'b0; req_addr = 32'h20; req_size = 2'd2;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsp(lat);
    chk("ign_lat", 32'(lat + 1), 32'(LATENCY));
    chk("ign_rdata", rsp_rdata, exp_rd);
    chk("ign_rdata_tp", rsp_rdata, 32'hDEAD55EF);
    finish_rsp(0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("ign_no_second", 32'(rsp_valid), 32'd0);
    end

    // Randomized traffic over a known-initialised region
    for (int w = 0; w < 16; w++) xact(1'b1, 32'(w*4), 2'd2, 1'b0, $urandom, 0, "init");
    for (int k = 0; k < 80; k++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 63));
      xact(1'($urandom), a, 2'($urandom_range(0, 3)), 1'($urandom), $urandom,
           $urandom_range(0, 3), "rnd");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
